// File: rtl/iir_coeff_loader_pkg.sv
// Shared types and constants for the IIR coefficient loader slice.
// Defaults form a 5 kHz low-pass at 96 kHz whose DC gain sums to 2^14.
package iir_pkg;

    localparam int PKG_COEFF_WIDTH = 18;
    localparam int PKG_COEFF_SCALE = 14;
    localparam int PKG_SUM_TOL     = 2;

    typedef logic signed [PKG_COEFF_WIDTH-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EVAL,
        WAIT_TICK
    } loader_state_t;

    localparam logic [2:0] ADDR_A2 = 3'd0;
    localparam logic [2:0] ADDR_A3 = 3'd1;
    localparam logic [2:0] ADDR_B1 = 3'd2;
    localparam logic [2:0] ADDR_B2 = 3'd3;
    localparam logic [2:0] ADDR_B3 = 3'd4;

    localparam int RESET_A2 = -25282;
    localparam int RESET_A3 = 10316;
    localparam int RESET_B1 = 354;
    localparam int RESET_B2 = 710;
    localparam int RESET_B3 = 354;

    // True when bits [31:w-1] are a pure sign extension of the low w bits.
    function automatic logic data_in_range(input logic [31:0] d, input int unsigned w);
        logic signed [31:0] hi;
        hi = $signed(d) >>> (w - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/iir_coeff_loader_if.sv
// Bridge-side register write / commit port of the coefficient loader.
interface iir_coeff_loader_if;

    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        commit;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready
    );

endinterface

// File: rtl/iir_coeff_sum_check.sv
// Sequential DC-gain check: accumulates +B1,+B2,+B3,-A2,-A3 over five cycles,
// then flags pass/fail for one cycle against 2^COEFF_SCALE +/- SUM_TOL.
module iir_coeff_sum_check
    import iir_pkg::*;
#(
    parameter int COEFF_WIDTH = PKG_COEFF_WIDTH,
    parameter int COEFF_SCALE = PKG_COEFF_SCALE,
    parameter int SUM_TOL     = PKG_SUM_TOL
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [COEFF_WIDTH-1:0] a2,
    input  logic signed [COEFF_WIDTH-1:0] a3,
    input  logic signed [COEFF_WIDTH-1:0] b1,
    input  logic signed [COEFF_WIDTH-1:0] b2,
    input  logic signed [COEFF_WIDTH-1:0] b3,
    output logic                          last,
    output logic                          pass,
    output logic                          fail
);

    localparam int AW = COEFF_WIDTH + 3;
    localparam logic signed [AW-1:0] TARGET = AW'(1 << COEFF_SCALE);
    localparam logic signed [AW-1:0] TOL_HI = AW'(SUM_TOL);
    localparam logic signed [AW-1:0] TOL_LO = -AW'(SUM_TOL);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] diff;
    logic [2:0]           idx;
    logic                 running;
    logic                 done;
    logic                 in_tol;

    always_comb begin
        term = '0;
        case (idx)
            3'd0:    term = AW'(b1);
            3'd1:    term = AW'(b2);
            3'd2:    term = AW'(b3);
            3'd3:    term = -AW'(a2);
            3'd4:    term = -AW'(a3);
            default: term = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            idx     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            idx     <= '0;
            running <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (running) begin
                acc <= acc + term;
                idx <= idx + 3'd1;
                if (idx == 3'd4) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        diff   = acc - TARGET;
        in_tol = (diff <= TOL_HI) && (diff >= TOL_LO);
        last   = running && (idx == 3'd4);
        pass   = done && in_tol;
        fail   = done && !in_tol;
    end

endmodule

// File: rtl/iir_coeff_loader.sv
// Shadow/active coefficient register pair for the biquad: host writes land in
// shadow, commit runs a DC-gain check, and the set swaps in on a sample tick.
module iir_coeff_loader
    import iir_pkg::*;
#(
    parameter int COEFF_WIDTH = PKG_COEFF_WIDTH,
    parameter int COEFF_SCALE = PKG_COEFF_SCALE,
    parameter int SUM_TOL     = PKG_SUM_TOL,
    parameter int DEF_A2      = RESET_A2,
    parameter int DEF_A3      = RESET_A3,
    parameter int DEF_B1      = RESET_B1,
    parameter int DEF_B2      = RESET_B2,
    parameter int DEF_B3      = RESET_B3
) (
    input  logic                          clk,
    input  logic                          reset,
    iir_coeff_loader_if.slave             bus,
    input  logic                          sample_tick,
    output logic signed [COEFF_WIDTH-1:0] A2,
    output logic signed [COEFF_WIDTH-1:0] A3,
    output logic signed [COEFF_WIDTH-1:0] B1,
    output logic signed [COEFF_WIDTH-1:0] B2,
    output logic signed [COEFF_WIDTH-1:0] B3,
    output logic                          applied,
    output logic                          filt_clear,
    output logic                          busy,
    output logic                          err_sum,
    output logic                          err_range,
    output logic                          err_drop
);

    localparam int CW = COEFF_WIDTH;

    loader_state_t state, state_nxt;

    logic signed [CW-1:0] sh_a2, sh_a3, sh_b1, sh_b2, sh_b3;
    logic bad;
    logic is_idle, in_range, bad_now;
    logic commit_seen, wr_ok, wr_bad, commit_ok, commit_bad;
    logic drop, revert, do_apply;
    logic chk_last, chk_pass, chk_fail;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (commit_ok)   state_nxt = CHECK;
            CHECK:     if (chk_last)    state_nxt = EVAL;
            EVAL:      state_nxt = chk_pass ? WAIT_TICK : IDLE;
            WAIT_TICK: if (sample_tick) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A bad write in the same cycle as commit poisons that commit as well.
    always_comb begin
        is_idle      = (state == IDLE);
        in_range     = data_in_range(bus.wr_data, CW);
        bad_now      = bad || (bus.wr_en && !in_range);
        commit_seen  = is_idle && bus.commit;
        wr_ok        = is_idle && bus.wr_en && in_range;
        wr_bad       = is_idle && bus.wr_en && !in_range;
        commit_ok    = commit_seen && !bad_now;
        commit_bad   = commit_seen && bad_now;
        drop         = !is_idle && (bus.wr_en || bus.commit);
        revert       = commit_bad || ((state == EVAL) && chk_fail);
        do_apply     = (state == WAIT_TICK) && sample_tick;
        busy         = !is_idle;
        bus.wr_ready = is_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a2 <= CW'(DEF_A2);
            sh_a3 <= CW'(DEF_A3);
            sh_b1 <= CW'(DEF_B1);
            sh_b2 <= CW'(DEF_B2);
            sh_b3 <= CW'(DEF_B3);
        end else if (revert) begin
            sh_a2 <= A2;
            sh_a3 <= A3;
            sh_b1 <= B1;
            sh_b2 <= B2;
            sh_b3 <= B3;
        end else if (wr_ok) begin
            case (bus.wr_addr)
                ADDR_A2: sh_a2 <= bus.wr_data[CW-1:0];
                ADDR_A3: sh_a3 <= bus.wr_data[CW-1:0];
                ADDR_B1: sh_b1 <= bus.wr_data[CW-1:0];
                ADDR_B2: sh_b2 <= bus.wr_data[CW-1:0];
                ADDR_B3: sh_b3 <= bus.wr_data[CW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            A2 <= CW'(DEF_A2);
            A3 <= CW'(DEF_A3);
            B1 <= CW'(DEF_B1);
            B2 <= CW'(DEF_B2);
            B3 <= CW'(DEF_B3);
        end else if (do_apply) begin
            A2 <= sh_a2;
            A3 <= sh_a3;
            B1 <= sh_b1;
            B2 <= sh_b2;
            B3 <= sh_b3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            applied    <= 1'b0;
            filt_clear <= 1'b0;
            bad        <= 1'b0;
            err_sum    <= 1'b0;
            err_range  <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            applied    <= do_apply;
            filt_clear <= do_apply;
            if (commit_seen)  bad <= 1'b0;
            else if (wr_bad)  bad <= 1'b1;
            if (commit_seen)  err_range <= commit_bad;
            else if (wr_bad)  err_range <= 1'b1;
            if (commit_seen)  err_sum <= 1'b0;
            else if ((state == EVAL) && chk_fail) err_sum <= 1'b1;
            if (commit_seen)  err_drop <= 1'b0;
            else if (drop)    err_drop <= 1'b1;
        end
    end

    iir_coeff_sum_check #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .COEFF_SCALE (COEFF_SCALE),
        .SUM_TOL     (SUM_TOL)
    ) u_sum_check (
        .clk   (clk),
        .reset (reset),
        .start (commit_ok),
        .a2    (sh_a2),
        .a3    (sh_a3),
        .b1    (sh_b1),
        .b2    (sh_b2),
        .b3    (sh_b3),
        .last  (chk_last),
        .pass  (chk_pass),
        .fail  (chk_fail)
    );

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: apply, sum failure, range error,
// dropped traffic while busy, tolerance edges and reset abort.
module tb_iir_coeff_loader;
    import iir_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_tick = 1'b0;
    logic signed [17:0] a2, a3, b1, b2, b3;
    logic applied, filt_clear, busy, err_sum, err_range, err_drop;

    int n_checks = 0;
    int n_pass   = 0;

    iir_coeff_loader_if bus ();

    iir_coeff_loader #(
        .COEFF_WIDTH (18),
        .COEFF_SCALE (14),
        .SUM_TOL     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sample_tick (sample_tick),
        .A2          (a2),
        .A3          (a3),
        .B1          (b1),
        .B2          (b2),
        .B3          (b3),
        .applied     (applied),
        .filt_clear  (filt_clear),
        .busy        (busy),
        .err_sum     (err_sum),
        .err_range   (err_range),
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic commit_pulse();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    task automatic tick_pulse();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int early;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;

        // 1: reset state
        do_reset();
        check_val("t1_a2", int'(a2), -25282);
        check_val("t1_a3", int'(a3), 10316);
        check_val("t1_b1", int'(b1), 354);
        check_val("t1_b2", int'(b2), 710);
        check_val("t1_b3", int'(b3), 354);
        check_val("t1_flags", int'({applied, filt_clear, busy, err_sum, err_range, err_drop}), 0);
        check_val("t1_wr_ready", int'(bus.wr_ready), 1);

        // 2: new set sums to 16384; early tick in CHECK ignored; apply at tick on cycle 20
        write_reg(ADDR_A2, -20000);
        write_reg(ADDR_A3, 8000);
        write_reg(ADDR_B1, 1096);
        write_reg(ADDR_B2, 2192);
        write_reg(ADDR_B3, 1096);
        write_reg(3'd6, 12345);
        commit_pulse();
        check_val("t2_busy", int'(busy), 1);
        check_val("t2_wr_ready", int'(bus.wr_ready), 0);
        early = 0;
        for (int i = 1; i < 20; i++) begin
            sample_tick = (i == 3);
            step();
            sample_tick = 1'b0;
            if (applied || filt_clear || (a2 != -18'sd25282)) early++;
        end
        check_val("t2_no_early_apply", early, 0);
        tick_pulse();
        check_val("t2_applied", int'(applied), 1);
        check_val("t2_filt_clear", int'(filt_clear), 1);
        check_val("t2_a2", int'(a2), -20000);
        check_val("t2_a3", int'(a3), 8000);
        check_val("t2_b1", int'(b1), 1096);
        check_val("t2_b2", int'(b2), 2192);
        check_val("t2_b3", int'(b3), 1096);
        check_val("t2_busy_done", int'(busy), 0);
        step();
        check_val("t2_pulse_end", int'({applied, filt_clear}), 0);

        // 3: B2=800 from defaults -> sum 16474, rejected and shadow reverts
        do_reset();
        write_reg(ADDR_B2, 800);
        commit_pulse();
        repeat (5) step();
        check_val("t3_eval_busy", int'(busy), 1);
        check_val("t3_err_sum_pre", int'(err_sum), 0);
        step();
        check_val("t3_err_sum", int'(err_sum), 1);
        check_val("t3_idle", int'(busy), 0);
        check_val("t3_b2_kept", int'(b2), 710);
        commit_pulse();
        check_val("t3_err_cleared", int'(err_sum), 0);
        repeat (6) step();
        tick_pulse();
        check_val("t3_reapply", int'(applied), 1);
        check_val("t3_shadow_b2", int'(b2), 710);
        check_val("t3_no_err", int'(err_sum), 0);

        // 4: value outside 18-bit signed range
        write_reg(ADDR_A2, 32'h0004_0000);
        check_val("t4_err_range", int'(err_range), 1);
        commit_pulse();
        check_val("t4_err_range_kept", int'(err_range), 1);
        early = 0;
        repeat (8) begin
            if (busy) early++;
            step();
        end
        check_val("t4_never_busy", early, 0);
        check_val("t4_a2", int'(a2), -25282);

        // 5: B1=356 (sum 16386, at tolerance); traffic while waiting is dropped
        write_reg(ADDR_B1, 356);
        commit_pulse();
        check_val("t5_range_cleared", int'(err_range), 0);
        repeat (6) step();
        check_val("t5_waiting", int'(busy), 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_B1;
        bus.wr_data = 1000;
        bus.commit  = 1'b1;
        step();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
        check_val("t5_err_drop", int'(err_drop), 1);
        check_val("t5_still_waiting", int'(busy), 1);
        tick_pulse();
        check_val("t5_applied", int'(applied), 1);
        check_val("t5_b1", int'(b1), 356);
        check_val("t5_err_sum", int'(err_sum), 0);

        // 6: B1=357 -> sum 16387, one past tolerance
        write_reg(ADDR_B1, 357);
        commit_pulse();
        check_val("t6_drop_cleared", int'(err_drop), 0);
        repeat (6) step();
        check_val("t6_err_sum", int'(err_sum), 1);
        check_val("t6_b1", int'(b1), 356);

        // 7: reset during CHECK cycle 3 aborts the commit
        write_reg(ADDR_A2, -20000);
        commit_pulse();
        repeat (2) step();
        check_val("t7_in_check", int'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check_val("t7_idle", int'(busy), 0);
        check_val("t7_a2", int'(a2), -25282);
        check_val("t7_b1", int'(b1), 354);
        check_val("t7_flags", int'({applied, err_sum, err_range, err_drop}), 0);
        early = 0;
        repeat (10) begin
            sample_tick = 1'b1;
            step();
            if (applied) early++;
        end
        sample_tick = 1'b0;
        check_val("t7_no_apply", early, 0);
        commit_pulse();
        repeat (6) step();
        tick_pulse();
        check_val("t7_default_shadow", int'(applied), 1);
        check_val("t7_a2_after", int'(a2), -25282);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
